// File: rtl/demux4_router.sv
// demux4_router: 1-to-4 demultiplexing router with a single-entry holding slot
// per output channel. An upstream word is steered to the channel named by
// select and held there until that channel's consumer takes it.
//
// Optional feature: define DEMUX4_ROUTER_COUNT_EN to add per-channel 8-bit
// drain counters (count_1..count_4, wrapping 255 -> 0).
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous active-high reset
//   in_valid   - upstream word present
//   in_ready   - router accepts the word this cycle (combinational)
//   select     - destination channel, 2'b00..2'b11 -> channels 1..4
//   in_data    - upstream word (bus_size+1 bits)
//   out_valid  - bit i-1 set when channel i holds a word
//   out_ready  - bit i-1 set when channel i consumer takes its word
//   line_1..4  - channel data
//   count_1..4 - drain counters (DEMUX4_ROUTER_COUNT_EN only)
module demux4_router #(
  parameter int unsigned bus_size = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        select,
  input  logic [bus_size:0] in_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [bus_size:0] line_1,
  output logic [bus_size:0] line_2,
  output logic [bus_size:0] line_3,
  output logic [bus_size:0] line_4
`ifdef DEMUX4_ROUTER_COUNT_EN
  ,
  output logic [7:0]        count_1,
  output logic [7:0]        count_2,
  output logic [7:0]        count_3,
  output logic [7:0]        count_4
`endif
);

  localparam int unsigned W   = bus_size + 1;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;

  // Per-channel slot state: 1 = FULL, 0 = EMPTY.
  logic [NCH-1:0] full_q, full_d;
  logic [W-1:0]   data_q [NCH];
  logic [W-1:0]   data_d [NCH];
  logic [NCH-1:0] drain;
  logic [NCH-1:0] load;

  // Slot accepts when empty or when its current word leaves this same cycle.
  always_comb begin
    in_ready = ~full_q[select] | out_ready[select];
  end

  // Drain/load strobes for the current cycle.
  always_comb begin
    drain = full_q & out_ready;
    load  = '0;
    if (in_valid && in_ready) begin
      load[select] = 1'b1;
    end
  end

  // Next slot state: a load wins over a simultaneous drain, keeping the slot FULL.
  always_comb begin
    full_d = (full_q & ~drain) | load;
    for (int unsigned i = 0; i < NCH; i++) begin
      data_d[i] = data_q[i];
      if (load[i]) begin
        data_d[i] = in_data;
      end
    end
  end

  // Slot state and holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Outputs come straight from the slot registers.
  always_comb begin
    out_valid = full_q;
    line_1    = data_q[0];
    line_2    = data_q[1];
    line_3    = data_q[2];
    line_4    = data_q[3];
  end

`ifdef DEMUX4_ROUTER_COUNT_EN
  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];

  // Drain counters wrap naturally at 8 bits.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i] + CW'(drain[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    count_1 = cnt_q[0];
    count_2 = cnt_q[1];
    count_3 = cnt_q[2];
    count_4 = cnt_q[3];
  end
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Testbench for demux4_router: the driver pushes every word it expects the
// router to accept into a per-channel queue; a separate monitor pops and
// compares whenever a channel presents a word that its consumer takes.
module tb_demux4_router;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   select = 2'b00;
  logic [W-1:0] in_data = '0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = 4'b0000;
  logic [W-1:0] line_1, line_2, line_3, line_4;
  logic [W-1:0] lines [4];
`ifdef DEMUX4_ROUTER_COUNT_EN
  logic [7:0]   count_1, count_2, count_3, count_4;
  logic [7:0]   counts [4];
  logic [7:0]   cnt_model [4];
`endif

  // Reference model: each channel is a queue of words accepted but not yet
  // taken; last[] is what a line shows once its channel is empty.
  logic [W-1:0] sb [4][$];
  logic [W-1:0] last [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux4_router #(.bus_size(W-1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .select   (select),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .line_1   (line_1),
    .line_2   (line_2),
    .line_3   (line_3),
    .line_4   (line_4)
`ifdef DEMUX4_ROUTER_COUNT_EN
    ,
    .count_1  (count_1),
    .count_2  (count_2),
    .count_3  (count_3),
    .count_4  (count_4)
`endif
  );

  assign lines[0] = line_1;
  assign lines[1] = line_2;
  assign lines[2] = line_3;
  assign lines[3] = line_4;
`ifdef DEMUX4_ROUTER_COUNT_EN
  assign counts[0] = count_1;
  assign counts[1] = count_2;
  assign counts[2] = count_3;
  assign counts[3] = count_4;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      sb[i].delete();
      last[i] = '0;
`ifdef DEMUX4_ROUTER_COUNT_EN
      cnt_model[i] = '0;
`endif
    end
  endtask

  // One stimulus cycle: drive at +1, check acceptance at +4 (after the monitor
  // has retired this cycle's drains at +2), push the word if accepted.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] ordy);
    logic exp_rdy;
    @(posedge clk);
    #1;
    in_valid  = v;
    select    = s;
    in_data   = d;
    out_ready = ordy;
    #3;
    exp_rdy = (sb[s].size() == 0);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (v && exp_rdy) sb[s].push_back(d);
  endtask

  // Hold reset for n cycles with random traffic, then release and clear the model.
  task automatic do_reset(input int n, input logic v);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      reset     = 1'b1;
      in_valid  = v;
      select    = 2'($urandom);
      in_data   = W'($urandom);
      out_ready = 4'($urandom);
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    select    = 2'($urandom);
    clear_model();
    #3;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
  endtask

  // Monitor: per channel, compare valid and line against the model and retire
  // words taken by the consumer this cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        for (int i = 0; i < 4; i++) begin
`ifdef DEMUX4_ROUTER_COUNT_EN
          check($sformatf("count_%0d", i + 1), 32'(counts[i]), 32'(cnt_model[i]));
`endif
          check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(sb[i].size() != 0));
          if (sb[i].size() != 0) begin
            check($sformatf("line_%0d", i + 1), 32'(lines[i]), 32'(sb[i][0]));
            if (out_ready[i]) begin
              last[i] = sb[i].pop_front();
`ifdef DEMUX4_ROUTER_COUNT_EN
              cnt_model[i] = cnt_model[i] + 8'd1;
`endif
            end
          end else begin
            check($sformatf("line_%0d_hold", i + 1), 32'(lines[i]), 32'(last[i]));
          end
        end
      end
    end
  end

  initial begin
    clear_model();

    // Reset: two cycles, then everything empty and zero.
    do_reset(2, 1'b0);
    cycle(1'b0, 2'b00, '0, 4'b0000);

    // Single transfer to channel 3, held 5 cycles, then taken.
    cycle(1'b1, 2'b10, 16'hA5A5, 4'b0000);
    for (int k = 0; k < 5; k++) cycle(1'b0, 2'b00, '0, 4'b0000);
    cycle(1'b0, 2'b00, '0, 4'b0100);
    cycle(1'b0, 2'b00, '0, 4'b0000);
    cycle(1'b0, 2'b00, '0, 4'b0000);

    // Backpressure on channel 1, then redirect to channel 2.
    cycle(1'b1, 2'b00, 16'h1111, 4'b0000);
    cycle(1'b1, 2'b00, 16'h2222, 4'b0000);
    cycle(1'b1, 2'b00, 16'h2222, 4'b0000);
    cycle(1'b1, 2'b01, 16'h3333, 4'b0000);
    cycle(1'b0, 2'b00, '0, 4'b1111);
    cycle(1'b0, 2'b00, '0, 4'b0000);

    // Full-rate throughput on channel 4.
    for (int k = 1; k <= 8; k++) cycle(1'b1, 2'b11, W'(k), 4'b1111);
    cycle(1'b0, 2'b00, '0, 4'b1111);
    cycle(1'b0, 2'b00, '0, 4'b0000);

    // Mid-operation reset with all channels full and a word in flight.
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), W'(16'hC000 + k), 4'b0000);
    do_reset(1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'($urandom), W'($urandom), 4'b1111);

    // Randomized traffic with random consumer readiness.
    for (int k = 0; k < 3000; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom), 4'($urandom));
    end

    // Drain everything; nothing may remain or appear.
    for (int k = 0; k < 4; k++) cycle(1'b0, 2'b00, '0, 4'b1111);
    @(posedge clk);
    #2;
    check("final_out_valid", 32'(out_valid), 32'd0);

`ifdef DEMUX4_ROUTER_COUNT_EN
    // 257 drains on channel 1 wrap its counter to 1.
    do_reset(1, 1'b0);
    for (int k = 0; k < 257; k++) cycle(1'b1, 2'b00, W'(k), 4'b0001);
    cycle(1'b0, 2'b00, '0, 4'b0001);
    cycle(1'b0, 2'b00, '0, 4'b0000);
    check("count_1_wrap", 32'(count_1), 32'd1);
    check("count_2_idle", 32'(count_2), 32'd0);
    check("count_3_idle", 32'(count_3), 32'd0);
    check("count_4_idle", 32'(count_4), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux4_router.md
DEMUX4_ROUTER -- requirements
Module: demux4_router

Interface
REQ-001 The parameter SHALL be bus_size, default 15, giving the MSB index of every data bus (width bus_size+1).
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be input, 1 bit: synchronous, active-high reset.
REQ-004 Port in_valid SHALL be input, 1 bit: upstream word present.
REQ-005 Port in_ready SHALL be output, 1 bit: router accepts the word this cycle.
REQ-006 Port select SHALL be input, 2 bits: destination channel, with 2'b00, 2'b01, 2'b10, 2'b11 selecting channels 1, 2, 3, 4.
REQ-007 Port in_data SHALL be input, bus_size+1 bits: upstream word.
REQ-008 Port out_valid SHALL be output, 4 bits: bit i-1 means channel i holds a word.
REQ-009 Port out_ready SHALL be input, 4 bits: bit i-1 means channel i consumer takes its word.
REQ-010 Ports line_1, line_2, line_3 and line_4 SHALL be outputs, bus_size+1 bits each: channel data.

Function
REQ-011 Each channel SHALL own one holding register plus a slot state, EMPTY or FULL.
REQ-012 A transfer-in SHALL occur exactly when in_valid and in_ready are both 1 in the same cycle.
REQ-013 in_ready SHALL be combinational: 1 when the slot addressed by select is EMPTY, or is FULL with its out_ready bit at 1 that cycle.
REQ-014 in_ready SHALL NOT depend on in_valid.
REQ-015 On a transfer-in, the addressed slot SHALL capture in_data and be FULL with out_valid set on the next cycle, giving a latency of 1 cycle.
REQ-016 A drain SHALL occur on channel i when out_valid[i-1] and out_ready[i-1] are both 1; that slot SHALL go EMPTY the next cycle unless REQ-017 applies.
REQ-017 A drain and a transfer-in on the same channel in the same cycle SHALL leave the slot FULL with the new word, so a full channel sustains 1 word per cycle.
REQ-018 Channels SHALL be independent: drains on several channels and one transfer-in to any channel SHALL all complete in the same cycle.
REQ-019 line_i SHALL be stable while out_valid[i-1] is 1 and out_ready[i-1] is 0.
REQ-020 line_i SHALL hold its last value after a drain until overwritten.
REQ-021 When in_valid is 0, select and in_data SHALL be ignored.
REQ-022 Words SHALL never be dropped or duplicated, and order SHALL be preserved per channel.

Reset
REQ-023 While reset is 1 at a clk edge, all slots SHALL go EMPTY, out_valid SHALL be 4'b0000, and line_1 through line_4 SHALL be all zeros.
REQ-024 Reset SHALL take priority over a simultaneous transfer-in or drain; words held or in flight SHALL be discarded.
REQ-025 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 With macro DEMUX4_ROUTER_COUNT_EN defined, the block SHALL add 8-bit outputs count_1 through count_4, each incrementing by 1 on each drain of its channel.
REQ-027 Each count SHALL wrap from 255 to 0 and SHALL be reset to 0 by reset.
REQ-028 Without DEMUX4_ROUTER_COUNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset test: reset 1 for 2 cycles, then release -> out_valid=4'b0000, line_1..line_4=0, in_ready=1.
REQ-030 Single transfer: select=2'b10, in_data=16'hA5A5, in_valid=1 for 1 cycle with out_ready=0 -> next cycle out_valid=4'b0100 and line_3=16'hA5A5, held for 5 cycles; out_ready[2]=1 for 1 cycle -> out_valid=4'b0000.
REQ-031 Backpressure test: channel 1 FULL with out_ready[0]=0, in_valid=1, select=2'b00 -> in_ready=0 and line_1 unchanged; switching select to 2'b01 -> in_ready=1 and the word lands on line_2.
REQ-032 Throughput test: out_ready=4'b1111, words 1..8 all to select=2'b11 on consecutive cycles -> in_ready stays 1 and line_4 shows 1..8 on 8 consecutive cycles.
REQ-033 Mid-operation reset: all four channels FULL, reset for 1 cycle with in_valid=1 -> out_valid=4'b0000 and no word appears afterward.
REQ-034 Counter test with DEMUX4_ROUTER_COUNT_EN: 257 drains on channel 1 -> count_1=1 and count_2..count_4=0.
